random_delay_timer: RTL

RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

---
 rtl/random_delay_timer_if.sv | 35 +++
 rtl/random_delay_timer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/random_delay_timer_if.sv
// ---------------------------------------------------------------------------
// random_delay_timer_if
// Bundles the request/status signals of random_delay_timer.
//   lfsr_value    : upstream LFSR word (B bits), free-running
//   start         : level request to begin a random delay
//   abort         : cancel a delay in progress
//   busy          : high whenever the timer is not idle
//   done          : one-cycle completion pulse
//   sampled_value : LFSR word captured at the accepted start
//   units_left    : remaining delay units (B+1 bits)
//   done_count    : completed (non-aborted) delays, modulo 256
// master = requester side, slave = timer side.
// ---------------------------------------------------------------------------
interface random_delay_timer_if #(
  parameter int B = 5
);
  logic [B-1:0] lfsr_value;
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic [B-1:0] sampled_value;
  logic [B:0]   units_left;
  logic [7:0]   done_count;

  modport master (
    output lfsr_value, start, abort,
    input  busy, done, sampled_value, units_left, done_count
  );

  modport slave (
    input  lfsr_value, start, abort,
    output busy, done, sampled_value, units_left, done_count
  );
endinterface

// File: rtl/random_delay_timer.sv
// ---------------------------------------------------------------------------
// random_delay_timer
// Waits a pseudo-random number of delay units, each PRESCALE clocks long.
// The unit count is the LFSR word captured at start plus MIN_UNITS.
//   clk   : system clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : random_delay_timer_if.slave (lfsr_value/start/abort in,
//           busy/done/sampled_value/units_left/done_count out)
// Parameters:
//   B         : LFSR word width (>= 4)
//   PRESCALE  : clocks per delay unit (>= 1)
//   MIN_UNITS : units added to the sampled word (0..2^B-1)
// ---------------------------------------------------------------------------
module random_delay_timer #(
  parameter int B         = 5,
  parameter int PRESCALE  = 50000,
  parameter int MIN_UNITS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  random_delay_timer_if.slave   bus
);

  // PRESCALE=1 still needs a one-bit counter; it simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [B:0]    MIN_EXT = (B+1)'(MIN_UNITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [B:0]    units_q, units_d;
  logic [B-1:0]  samp_q, samp_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [B:0]    load_total;
  logic          tick;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    units_d = units_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;

    // B+1 bits hold (2^B-1) + (2^B-1) without overflow.
    load_total = {1'b0, bus.lfsr_value} + MIN_EXT;
    tick       = (pre_q == PRE_MAX);

    case (state_q)
      IDLE: begin
        // abort is irrelevant here; start always wins in IDLE.
        if (bus.start) begin
          samp_d  = bus.lfsr_value;
          units_d = load_total;
          pre_d   = '0;
          state_d = (load_total == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // abort beats a coinciding final tick; counters freeze where they are.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (tick) begin
          pre_d   = '0;
          units_d = units_q - 1'b1;
          if (units_q == {{B{1'b0}}, 1'b1}) begin
            state_d = DONE;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state, so they line up
    // with state_q and carry no combinational path from the inputs.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      units_q <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      units_q <= units_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sampled_value = samp_q;
  assign bus.units_left    = units_q;
  assign bus.done_count    = cnt_q;

endmodule
